// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT ingress pipeline: stream widths, arbiter state
// encoding and packet-counter width.
package rmt_pkg;

    localparam int AXIS_DATA_W  = 512;
    localparam int AXIS_TUSER_W = 128;
    localparam int PKT_CNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Free-running packet counter step; wraps naturally at all-ones.
    function automatic logic [PKT_CNT_W-1:0] cnt_inc(input logic [PKT_CNT_W-1:0] c);
        return c + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register: one cycle of latency, holds while stalled and
// reloads on the same edge the held beat drains, so throughput stays at 1 beat/cycle.
module axis_reg_slice #(
    parameter int DW = 512,
    parameter int UW = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_tdata,
    input  logic [DW/8-1:0] s_tkeep,
    input  logic [UW-1:0]   s_tuser,
    input  logic            s_tlast,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic [DW/8-1:0] m_tkeep,
    output logic [UW-1:0]   m_tuser,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready
);

    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_ingress_arb.sv
// Packet-atomic two-port ingress arbiter: merges the data-plane (s0) and
// control-plane (s1) streams into one registered stream with round-robin ties.
module axis_ingress_arb
    import rmt_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = AXIS_TUSER_W
) (
    input  logic                               clk,
    input  logic                               areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s0_axis_tuser,
    input  logic                               s0_axis_tvalid,
    input  logic                               s0_axis_tlast,
    output logic                               s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s1_axis_tuser,
    input  logic                               s1_axis_tvalid,
    input  logic                               s1_axis_tlast,
    output logic                               s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,

    output logic [PKT_CNT_W-1:0]               pkt_cnt_0,
    output logic [PKT_CNT_W-1:0]               pkt_cnt_1
);

    arb_state_t state;
    logic       last_grant;
    logic [1:0] rst_sync;
    logic       rst_hold;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   sel_tdata;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  sel_tuser;
    logic                             sel_tlast;
    logic                             sel_tvalid;
    logic                             slice_ready;

    // Reset asserts asynchronously but is released two clk edges later.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) rst_sync <= 2'b11;
        else        rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_hold = rst_sync[1];

    always_comb begin
        sel_tdata = s0_axis_tdata;
        sel_tkeep = s0_axis_tkeep;
        sel_tuser = s0_axis_tuser;
        sel_tlast = s0_axis_tlast;
        if (state == GNT1) begin
            sel_tdata = s1_axis_tdata;
            sel_tkeep = s1_axis_tkeep;
            sel_tuser = s1_axis_tuser;
            sel_tlast = s1_axis_tlast;
        end
    end

    assign sel_tvalid     = (state == GNT0 && s0_axis_tvalid) || (state == GNT1 && s1_axis_tvalid);
    assign s0_axis_tready = (state == GNT0) && slice_ready;
    assign s1_axis_tready = (state == GNT1) && slice_ready;

    // Grant holds until the granted port's tlast is accepted; IDLE is the bubble.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_cnt_0  <= '0;
            pkt_cnt_1  <= '0;
        end else if (!rst_hold) begin
            case (state)
                IDLE: begin
                    if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (s1_axis_tvalid) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                GNT0: begin
                    if (s0_axis_tvalid && s0_axis_tready && s0_axis_tlast) begin
                        state     <= IDLE;
                        pkt_cnt_0 <= cnt_inc(pkt_cnt_0);
                    end
                end
                GNT1: begin
                    if (s1_axis_tvalid && s1_axis_tready && s1_axis_tlast) begin
                        state     <= IDLE;
                        pkt_cnt_1 <= cnt_inc(pkt_cnt_1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .DW(C_S_AXIS_DATA_WIDTH),
        .UW(C_S_AXIS_TUSER_WIDTH)
    ) u_out_slice (
        .clk      (clk),
        .rst      (areset),
        .s_tdata  (sel_tdata),
        .s_tkeep  (sel_tkeep),
        .s_tuser  (sel_tuser),
        .s_tlast  (sel_tlast),
        .s_tvalid (sel_tvalid),
        .s_tready (slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_ingress_arb.sv
// Bench for axis_ingress_arb: randomized packets, an expected-output packet order
// derived from the arbitration rules, and per-cycle latency/stall/ordering checks.
module tb_axis_ingress_arb;
    import rmt_pkg::*;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk;
    logic          areset;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
    logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic [31:0]   pkt_cnt_0, pkt_cnt_1;

    axis_ingress_arb #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW)
    ) dut (
        .clk(clk), .areset(areset),
        .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
        .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
        .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source queues, and the expected output stream in predicted packet order.
    beat_t q0[$], q1[$], exp_q[$];
    bit    rdy_q[$];
    int    total, bad, cyc, pkt_id;
    int    rdy_mode, gap_pct;
    bit    prev_acc, prev_stall;
    beat_t prev_in, prev_out;
    int    acc0_n, first0_cyc, last0_cyc, first1_cyc;
    logic [31:0] exp_cnt0, exp_cnt1;

    task automatic add_pkt(input int port, input int len);
        beat_t b;
        pkt_id++;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(port), 8'(pkt_id), 16'(i), 32'($urandom())};
            b.keep = 8'($urandom());
            b.user = 16'($urandom());
            b.last = (i == len - 1);
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
            exp_q.push_back(b);
        end
        if (port == 0) exp_cnt0 = exp_cnt0 + 32'd1;
        else           exp_cnt1 = exp_cnt1 + 32'd1;
    endtask

    task automatic cycle();
        beat_t ob;
        bit a0, a1;
        @(negedge clk);
        cyc++;
        s0_tvalid = (q0.size() > 0) && ($urandom_range(99) >= gap_pct);
        if (q0.size() > 0) {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = q0[0];
        s1_tvalid = (q1.size() > 0);
        if (q1.size() > 0) {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = q1[0];
        if (rdy_mode == 0)      m_tready = 1'b1;
        else if (rdy_mode == 1) m_tready = 1'($urandom_range(1));
        else if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
        else                       m_tready = 1'b1;
        #1;
        ob = {m_tdata, m_tkeep, m_tuser, m_tlast};
        if (prev_acc) begin
            total++;
            if (!(m_tvalid === 1'b1 && ob === prev_in)) begin
                bad++;
                $display("FAIL latency: got v=%0b %h, want v=1 %h", m_tvalid, ob, prev_in);
            end
        end
        if (prev_stall) begin
            total++;
            if (!(m_tvalid === 1'b1 && ob === prev_out)) begin
                bad++;
                $display("FAIL stall_hold: got v=%0b %h, want v=1 %h", m_tvalid, ob, prev_out);
            end
        end
        a0 = s0_tvalid && s0_tready;
        a1 = s1_tvalid && s1_tready;
        total++;
        if (a0 && a1) begin
            bad++;
            $display("FAIL dual_ready: got both ports accepted, want at most one");
        end
        if (m_tvalid && m_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat: got %h, want no beat", ob);
            end else begin
                if (ob !== exp_q[0]) begin
                    bad++;
                    $display("FAIL out_order: got %h, want %h", ob, exp_q[0]);
                end
                exp_q.delete(0);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = ob;
        prev_acc   = a0 || a1;
        if (a0) begin
            prev_in = q0[0];
            if (first0_cyc < 0) first0_cyc = cyc;
            if (q0[0].last) last0_cyc = cyc;
            acc0_n++;
        end
        if (a1) begin
            prev_in = q1[0];
            if (first1_cyc < 0) first1_cyc = cyc;
        end
        @(posedge clk);
        if (a0) q0.delete(0);
        if (a1) q1.delete(0);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || m_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s timeout: got %0d beats outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic check_counts(input string name);
        total++;
        if (pkt_cnt_0 !== exp_cnt0 || pkt_cnt_1 !== exp_cnt1) begin
            bad++;
            $display("FAIL %s counts: got %0d/%0d, want %0d/%0d", name, pkt_cnt_0, pkt_cnt_1, exp_cnt0, exp_cnt1);
        end
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        m_tready  = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete(); rdy_q.delete();
        prev_acc = 0; prev_stall = 0;
        exp_cnt0 = '0; exp_cnt1 = '0;
        acc0_n = 0; first0_cyc = -1; last0_cyc = -1; first1_cyc = -1;
        rdy_mode = 0; gap_pct = 0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if ({m_tvalid, m_tlast, s0_tready, s1_tready} !== 4'b0 || m_tdata !== '0 ||
            m_tkeep !== '0 || m_tuser !== '0 || pkt_cnt_0 !== '0 || pkt_cnt_1 !== '0) begin
            bad++;
            $display("FAIL %s: got v=%0b l=%0b rdy=%0b%0b d=%h k=%h u=%h c=%0d/%0d, want all 0", name,
                     m_tvalid, m_tlast, s0_tready, s1_tready, m_tdata, m_tkeep, m_tuser, pkt_cnt_0, pkt_cnt_1);
        end
    endtask

    task automatic test_reset();
        s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 1'b0;
        s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 1'b0;
        areset = 1'b1;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        m_tready  = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_state");
        total++;
        if (dut.state !== IDLE) begin
            bad++;
            $display("FAIL reset_fsm: got %0d, want IDLE", dut.state);
        end
    endtask

    task automatic test_single_port();
        do_reset();
        add_pkt(0, 3);
        drain("single", 200);
        total++;
        if (last0_cyc - first0_cyc != 2) begin
            bad++;
            $display("FAIL single_b2b: got span %0d cycles, want 2", last0_cyc - first0_cyc);
        end
        check_counts("single");
    endtask

    // Both valid from reset: last_grant starts at 1 so s0 goes first.
    task automatic test_tie();
        do_reset();
        add_pkt(0, 3);
        add_pkt(1, 2);
        drain("tie", 200);
        total++;
        if (first1_cyc != last0_cyc + 2) begin
            bad++;
            $display("FAIL tie_bubble: got s1 start %0d, want %0d", first1_cyc, last0_cyc + 2);
        end
        check_counts("tie");
    endtask

    // Continuous traffic on both ports must alternate s0,s1,s0,...
    task automatic test_alternate();
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            add_pkt(0, 1 + $urandom_range(3));
            add_pkt(1, 1 + $urandom_range(3));
        end
        drain("alternate", 3000);
        check_counts("alternate");
    endtask

    task automatic test_stall();
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 12; i++) begin
            rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
            rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
        end
        add_pkt(0, 4);
        add_pkt(1, 4);
        drain("stall", 500);
        check_counts("stall");
    endtask

    // Granted port drops tvalid mid-packet; the grant must simply wait.
    task automatic test_gap();
        do_reset();
        rdy_mode = 1;
        gap_pct  = 50;
        add_pkt(0, 4);
        add_pkt(0, 5);
        drain("gap", 1000);
        check_counts("gap");
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.pkt_cnt_1 = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_1;
        exp_cnt1 = 32'hFFFF_FFFF;
        add_pkt(1, 1);
        drain("wrap", 200);
        check_counts("wrap");
        total++;
        if (dut.state !== IDLE) begin
            bad++;
            $display("FAIL wrap_idle: got %0d, want IDLE", dut.state);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        add_pkt(0, 5);
        n = 0;
        while (acc0_n < 2 && n < 100) begin
            cycle();
            n++;
        end
        total++;
        if (acc0_n < 2) begin
            bad++;
            $display("FAIL reset_mid_start: got %0d beats accepted, want 2", acc0_n);
        end
        #1;
        areset = 1'b1;
        #1;
        check_zero_outputs("reset_mid");
        do_reset();
        add_pkt(0, 4);
        add_pkt(1, 2);
        drain("after_reset", 300);
        check_counts("after_reset");
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; pkt_id = 0;
        test_reset();
        test_single_port();
        test_tie();
        test_alternate();
        test_stall();
        test_gap();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
